// File: rtl/modport_mem.sv
// rtl/modport_mem.sv - single-byte HyperRAM controller bridging a simple req/busy port to HyperBus
// One transaction at a time: CA phase, latency wait, then a 2-byte masked write or a 2-byte read.
module modport_mem #(
  parameter int LATENCY = 6,
  parameter int TCSHI   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        rd_rdy,
  output logic        hb_ck,
  output logic        hb_cs_n,
  output logic        hb_rst_n,
  output logic [7:0]  hb_dq_o,
  input  logic [7:0]  hb_dq_i,
  output logic        hb_dq_oe,
  output logic        hb_rwds_o,
  input  logic        hb_rwds_i,
  output logic        hb_rwds_oe
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CA    = 3'd1,
    LAT   = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4,
    CSHI  = 3'd5
  } state_e;

  localparam logic [7:0] LAT_SGL_LAST = 8'(2 * LATENCY - 1);
  localparam logic [7:0] LAT_DBL_LAST = 8'(4 * LATENCY - 1);
  localparam logic [7:0] CSHI_LAST    = 8'(TCSHI - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        is_rd_q, is_rd_d;
  logic        dbl_q, dbl_d;
  logic        ck_q, ck_d;
  logic        rwds_prev_q, rwds_prev_d;
  logic        cap_q, cap_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_rdy_q, rd_rdy_d;
  logic        busy_q, busy_d;
  logic        rst_n_q;
  logic [47:0] ca_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_rd_q     <= 1'b0;
      dbl_q       <= 1'b0;
      ck_q        <= 1'b0;
      rwds_prev_q <= 1'b0;
      cap_q       <= 1'b0;
      byte0_q     <= '0;
      rdata_q     <= '0;
      rd_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      rst_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_rd_q     <= is_rd_d;
      dbl_q       <= dbl_d;
      ck_q        <= ck_d;
      rwds_prev_q <= rwds_prev_d;
      cap_q       <= cap_d;
      byte0_q     <= byte0_d;
      rdata_q     <= rdata_d;
      rd_rdy_q    <= rd_rdy_d;
      busy_q      <= busy_d;
      rst_n_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_rd_d     = is_rd_q;
    dbl_d       = dbl_q;
    cap_d       = cap_q;
    byte0_d     = byte0_q;
    rdata_d     = rdata_q;
    rd_rdy_d    = 1'b0;
    rwds_prev_d = hb_rwds_i;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_req || rd_req) begin
          state_d = CA;
          addr_d  = addr;
          wdata_d = wdata;
          is_rd_d = ~wr_req;  // write wins when both are requested
          dbl_d   = 1'b0;
        end
      end
      CA: begin
        if (cnt_q == 8'd1) dbl_d = hb_rwds_i;
        if (cnt_q == 8'd5) begin
          cnt_d   = '0;
          state_d = LAT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LAT: begin
        if (cnt_q == (dbl_q ? LAT_DBL_LAST : LAT_SGL_LAST)) begin
          cnt_d   = '0;
          cap_d   = 1'b0;
          state_d = is_rd_q ? RDATA : WDATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WDATA: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = CSHI;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RDATA: begin
        // Device strobes each byte with an RWDS transition; even byte arrives first.
        if (hb_rwds_i != rwds_prev_q) begin
          if (!cap_q) begin
            byte0_d = hb_dq_i;
            cap_d   = 1'b1;
          end else begin
            rdata_d  = addr_q[0] ? hb_dq_i : byte0_q;
            rd_rdy_d = 1'b1;
            cnt_d    = '0;
            state_d  = CSHI;
          end
        end
      end
      CSHI: begin
        if (cnt_q == CSHI_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    ck_d   = ((state_d == CA) || (state_d == LAT) || (state_d == WDATA) || (state_d == RDATA))
             ? ~ck_q : 1'b0;
  end

  always_comb begin
    ca_word    = {is_rd_q, 1'b0, 1'b1, 1'b0, addr_q[31:4], 13'd0, addr_q[3:1]};
    hb_cs_n    = 1'b1;
    hb_dq_o    = '0;
    hb_dq_oe   = 1'b0;
    hb_rwds_o  = 1'b0;
    hb_rwds_oe = 1'b0;
    case (state_q)
      CA: begin
        hb_cs_n  = 1'b0;
        hb_dq_oe = 1'b1;
        case (cnt_q[2:0])
          3'd0:    hb_dq_o = ca_word[47:40];
          3'd1:    hb_dq_o = ca_word[39:32];
          3'd2:    hb_dq_o = ca_word[31:24];
          3'd3:    hb_dq_o = ca_word[23:16];
          3'd4:    hb_dq_o = ca_word[15:8];
          default: hb_dq_o = ca_word[7:0];
        endcase
      end
      LAT, RDATA: hb_cs_n = 1'b0;
      WDATA: begin
        hb_cs_n    = 1'b0;
        hb_dq_o    = wdata_q;
        hb_dq_oe   = 1'b1;
        hb_rwds_oe = 1'b1;
        // RWDS high masks the lane that is not being written.
        hb_rwds_o  = cnt_q[0] ? ~addr_q[0] : addr_q[0];
      end
      default: hb_cs_n = 1'b1;
    endcase
  end

  assign hb_ck    = ck_q;
  assign hb_rst_n = rst_n_q;
  assign busy     = busy_q;
  assign rd_rdy   = rd_rdy_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_modport_mem.sv
// tb/tb_modport_mem.sv - scoreboard bench for modport_mem
// Stimulus pushes expected bus bytes / read data; a negedge monitor pops and compares.
module tb_modport_mem;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        busy, rd_rdy, hb_ck, hb_cs_n, hb_rst_n;
  logic [7:0]  hb_dq_o;
  logic [7:0]  hb_dq_i = '0;
  logic        hb_dq_oe, hb_rwds_o, hb_rwds_oe;
  logic        hb_rwds_i = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  modport_mem #(.LATENCY(6), .TCSHI(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_req(wr_req), .rd_req(rd_req),
    .wdata(wdata), .rdata(rdata), .busy(busy), .rd_rdy(rd_rdy), .hb_ck(hb_ck),
    .hb_cs_n(hb_cs_n), .hb_rst_n(hb_rst_n), .hb_dq_o(hb_dq_o), .hb_dq_i(hb_dq_i),
    .hb_dq_oe(hb_dq_oe), .hb_rwds_o(hb_rwds_o), .hb_rwds_i(hb_rwds_i),
    .hb_rwds_oe(hb_rwds_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected entries: 1xxx = bus byte {rwds_oe, rwds_o, dq}, 2xxx = read data.
  task automatic push_bus(input logic [9:0] v);
    exp_q.push_back({4'h1, 2'b00, v});
  endtask

  task automatic push_ca(input logic [7:0] b0, b1, b2, b3, b4, b5);
    push_bus({2'b00, b0}); push_bus({2'b00, b1}); push_bus({2'b00, b2});
    push_bus({2'b00, b3}); push_bus({2'b00, b4}); push_bus({2'b00, b5});
  endtask

  task automatic observe(input string name, input logic [15:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output %0h, expected nothing", name, obs);
    end else begin
      check(name, obs, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (!hb_cs_n && hb_dq_oe) observe("bus_byte", {4'h1, 2'b00, hb_rwds_oe, hb_rwds_o, hb_dq_o});
      if (rd_rdy) observe("rd_data", {8'h20, rdata});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a one-cycle request; returns at the negedge after the accepting edge.
  task automatic request(input logic w, input logic r, input logic [31:0] a, input logic [7:0] d);
    wr_req = w; rd_req = r; addr = a; wdata = d;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_idle(input int n0, output int n);
    n = n0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input int gap);
    int n;
    request(1'b0, 1'b1, a, 8'h00);
    step(18 + gap);
    hb_dq_i = b0; hb_rwds_i = 1'b1;
    step(1);
    hb_dq_i = b1; hb_rwds_i = 1'b0;
    step(1);
    check("rd_rdy_after_2nd_edge", rd_rdy, 1);
    step(1);
    check("rd_rdy_one_cycle", rd_rdy, 0);
    wait_idle(0, n);
    check("read_idle", busy, 0);
  endtask

  initial begin
    int n;
    step(3);
    check("rst_busy", busy, 0);
    check("rst_rd_rdy", rd_rdy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cs_n", hb_cs_n, 1);
    check("rst_ck", hb_ck, 0);
    check("rst_hb_rst_n", hb_rst_n, 0);
    check("rst_oes", {hb_dq_oe, hb_rwds_oe}, 0);
    check("rst_outs", {hb_dq_o, hb_rwds_o}, 0);
    reset = 1'b1;
    step(2);
    check("post_rst_busy", busy, 0);
    check("post_rst_hb_rst_n", hb_rst_n, 1);

    // Single-latency write, even address
    push_ca(8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
    push_bus(10'h2A5); push_bus(10'h3A5);
    request(1'b1, 1'b0, 32'h0000_0010, 8'hA5);
    check("busy_set", busy, 1);
    check("ck_first", hb_ck, 1);
    check("cs_low", hb_cs_n, 0);
    step(1);
    check("ck_toggle", hb_ck, 0);
    wait_idle(1, n);
    check("wr_latency_single", n, 22);

    // Reads: odd and even byte select
    push_ca(8'hA0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
    exp_q.push_back(16'h205A);
    do_read(32'h0000_0011, 8'h3C, 8'h5A, 0);
    push_ca(8'hA0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
    exp_q.push_back(16'h203C);
    do_read(32'h0000_0010, 8'h3C, 8'h5A, 3);
    check("rdata_held", rdata, 8'h3C);

    // Double-latency write, odd address
    push_ca(8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h05);
    push_bus(10'h33C); push_bus(10'h23C);
    hb_rwds_i = 1'b1;
    request(1'b1, 1'b0, 32'h0000_002B, 8'h3C);
    step(6);
    hb_rwds_i = 1'b0;
    wait_idle(6, n);
    check("wr_latency_double", n, 34);

    // Simultaneous wr+rd: write wins; a request during busy is ignored
    push_ca(8'h20, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00);
    push_bus(10'h277); push_bus(10'h377);
    request(1'b1, 1'b1, 32'h0000_0100, 8'h77);
    step(4);
    request(1'b0, 1'b1, 32'h0000_0200, 8'h00);
    wait_idle(5, n);
    check("wr_both_latency", n, 22);
    step(5);
    check("no_retrigger", busy, 0);

    // Reset during LAT aborts immediately
    push_ca(8'hA0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
    request(1'b0, 1'b1, 32'h0000_0011, 8'h00);
    step(10);
    reset = 1'b0;
    #1;
    check("abort_cs_n", hb_cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_ck", hb_ck, 0);
    check("abort_hb_rst_n", hb_rst_n, 0);
    step(2);
    reset = 1'b1;
    step(30);
    check("abort_idle", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
